// File: rtl/rv32i_mini_system.sv
// rv32i_mini_system: single-cycle RV32I integer-subset core with private
// program and data memories. Memories are preloaded externally while the
// core is held in reset; they are never cleared by reset.
`timescale 1ns/1ps

// Program memory: combinational read, write port kept idle by the core.
module mem_prog #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] progArray [0:WORDS-1];

  // Optional word write; the core never asserts it so the program is read-only.
  always_ff @(posedge clk) begin
    if (we) progArray[waddr] <= wdata;
  end

  assign rdata = progArray[addr];
endmodule

// Data memory: combinational read, full-word synchronous write.
module mem_data #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] dataArray [0:WORDS-1];

  // Store path: one word per edge when enabled.
  always_ff @(posedge clk) begin
    if (we) dataArray[addr] <= wdata;
  end

  assign rdata = dataArray[addr];
endmodule

module rv32i_mini_system #(
  parameter int          PROG_WORDS = 256,
  parameter int          DATA_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data,
  output logic        illegal_o
);
  // Depths are powers of two, so slicing the word index gives the modulo wrap.
  localparam int PAW = $clog2(PROG_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_q, pc_next;
  logic [31:0] xreg [0:31];
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, dm_addr, dm_rdata;
  logic [31:0] rd_wdata;
  logic        rd_we, dm_we, illegal;
  logic        unused_addr_bits;

  // Integer ALU shared by register-register and register-immediate forms.
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, sa < sb};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Branch condition evaluation; funct3 010/011 are screened out as illegal.
  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = (sa < sb);
      3'b101:  br_taken = (sa >= sb);
      3'b110:  br_taken = (a < b);
      default: br_taken = (a >= b);
    endcase
  endfunction

  mem_prog #(.WORDS(PROG_WORDS)) mem_prog_inst (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc_q[PAW+1:2]),
    .rdata (instr)
  );

  mem_data #(.WORDS(DATA_WORDS)) mem_data_inst (
    .clk   (clk),
    .we    (dm_we & rst_n),
    .addr  (dm_addr[DAW+1:2]),
    .wdata (rs2_val),
    .rdata (dm_rdata)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : xreg[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : xreg[rs2];
  assign dm_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign unused_addr_bits = ^{dm_addr[31:DAW+2], dm_addr[1:0]};

  // Decode/execute: next PC, register writeback, store enable, illegal flag.
  always_comb begin
    pc_next  = pc_q + 32'd4;
    rd_we    = 1'b0;
    rd_wdata = 32'd0;
    dm_we    = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + 32'd4;
        pc_next  = pc_q + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_q + 32'd4;
          pc_next  = (rs1_val + imm_i) & ~32'd1;
        end else illegal = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3[2:1] == 2'b01) illegal = 1'b1;
        else if (br_taken(funct3, rs1_val, rs2_val)) pc_next = pc_q + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_we    = 1'b1;
          rd_wdata = dm_rdata;
        end else illegal = 1'b1;
      end
      OP_STORE: begin
        if (funct3 == 3'b010) dm_we = 1'b1;
        else illegal = 1'b1;
      end
      OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
          illegal = 1'b1;
        end else begin
          rd_we    = 1'b1;
          rd_wdata = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_val, imm_i);
        end
      end
      OP_REG: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          rd_we    = 1'b1;
          rd_wdata = alu(funct3, instr[30], rs1_val, rs2_val);
        end else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Architectural state: PC and x1..x31, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) xreg[i] <= 32'd0;
    end else begin
      pc_q <= pc_next;
      if (rd_we && rd != 5'd0) xreg[rd] <= rd_wdata;
    end
  end

  assign pc_o         = pc_q;
  assign instr_o      = instr;
  assign illegal_o    = illegal;
  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : xreg[dbg_reg_addr];
endmodule

// File: tb/tb_rv32i_mini_system.sv
// Testbench for rv32i_mini_system: directed programs from the test plan plus
// random programs checked against an instruction-level model.
`timescale 1ns/1ps

module tb_rv32i_mini_system;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  dbg_reg_addr = 5'd0;
  logic [31:0] pc_o, instr_o, dbg_reg_data;
  logic        illegal_o;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_mini_system #(.PROG_WORDS(256), .DATA_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_o         (pc_o),
    .instr_o      (instr_o),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_prog [256];
  logic [31:0] m_data [256];
  logic [31:0] m_x    [32];
  logic [31:0] m_pc;

  // Legal encodings as mask/match pairs, in this order:
  // LUI AUIPC JAL JALR BEQ BNE BLT BGE BLTU BGEU LW SW ADDI SLTI SLTIU XORI ORI
  // ANDI SLLI SRLI SRAI ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
  logic [31:0] t_mask [31] = '{
    32'h7F, 32'h7F, 32'h7F, 32'h707F,
    32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
    32'h707F, 32'h707F,
    32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F};
  logic [31:0] t_match [31] = '{
    32'h37, 32'h17, 32'h6F, 32'h67,
    32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
    32'h2003, 32'h2023,
    32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
    32'h1013, 32'h5013, 32'h40005013,
    32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
    32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};

  function automatic int find_op(input logic [31:0] ins);
    for (int k = 0; k < 31; k++)
      if ((ins & t_mask[k]) == t_match[k]) return k;
    return -1;
  endfunction

  // Execute one instruction on the model.
  function automatic void m_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, val, nxt, ea;
    logic [4:0]  rd, sh;
    int k;
    ins = m_prog[m_pc[9:2]];
    k   = find_op(ins);
    rd  = ins[11:7];
    sh  = ins[24:20];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = $signed(ins) >>> 20;
    is  = (ii & ~32'h1F) | {27'd0, ins[11:7]};
    ib  = (($signed(ins) >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11) |
          (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    iu  = ins & 32'hFFFF_F000;
    ij  = (($signed(ins) >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
          (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    ea  = a + ((k == 11) ? is : ii);
    nxt = m_pc + 4;
    val = 0;
    case (k)
      0:  val = iu;
      1:  val = m_pc + iu;
      2:  begin val = m_pc + 4; nxt = m_pc + ij; end
      3:  begin val = m_pc + 4; nxt = (a + ii) & ~32'h1; end
      4:  if (a == b) nxt = m_pc + ib;
      5:  if (a != b) nxt = m_pc + ib;
      6:  if ($signed(a) < $signed(b)) nxt = m_pc + ib;
      7:  if ($signed(a) >= $signed(b)) nxt = m_pc + ib;
      8:  if (a < b) nxt = m_pc + ib;
      9:  if (a >= b) nxt = m_pc + ib;
      10: val = m_data[ea[9:2]];
      11: m_data[ea[9:2]] = b;
      12: val = a + ii;
      13: val = ($signed(a) < $signed(ii)) ? 1 : 0;
      14: val = (a < ii) ? 1 : 0;
      15: val = a ^ ii;
      16: val = a | ii;
      17: val = a & ii;
      18: val = a << sh;
      19: val = a >> sh;
      20: val = $signed(a) >>> sh;
      21: val = a + b;
      22: val = a - b;
      23: val = a << b[4:0];
      24: val = ($signed(a) < $signed(b)) ? 1 : 0;
      25: val = (a < b) ? 1 : 0;
      26: val = a ^ b;
      27: val = a >> b[4:0];
      28: val = $signed(a) >>> b[4:0];
      29: val = a | b;
      30: val = a & b;
      default: ;
    endcase
    if (k >= 0 && !(k >= 4 && k <= 9) && k != 11 && rd != 0) m_x[rd] = val;
    m_pc = nxt;
  endfunction

  task automatic set_prog(input int idx, input logic [31:0] w);
    dut.mem_prog_inst.progArray[idx] = w;
    m_prog[idx] = w;
  endtask

  task automatic set_data(input int idx, input logic [31:0] w);
    dut.mem_data_inst.dataArray[idx] = w;
    m_data[idx] = w;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    #1;
    m_pc = 32'h0;
    for (int r = 0; r < 32; r++) m_x[r] = 32'h0;
    for (int i = 0; i < 256; i++) begin
      set_prog(i, 32'h0000_0013);
      set_data(i, 32'h0);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_reg_addr = 5'(r);
    #0.1;
    v = dbg_reg_data;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] ld [4];
    hold_reset();
    for (int i = 0; i < 4; i++) begin
      set_prog(i, $urandom);
      ld[i] = $urandom;
      set_data(i, ld[i]);
    end
    n_checks++;
    if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc_held: got %h expected %h", pc_o, 32'h0); end
    release_reset();
    n_checks++;
    if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
    n_checks++;
    if (instr_o !== m_prog[0]) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr_o, m_prog[0]); end
    for (int r = 0; r < 32; r++) begin
      read_reg(r, v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_x%0d: got %h expected %h", r, v, 32'h0); end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.mem_data_inst.dataArray[i] !== ld[i]) begin
        n_fail++; $display("FAIL reset_data%0d: got %h expected %h", i, dut.mem_data_inst.dataArray[i], ld[i]);
      end
    end
  endtask

  task automatic test_jal();
    logic [31:0] v;
    hold_reset();
    set_prog(0, 32'h008000EF);
    set_prog(2, 32'h00008067);
    release_reset();
    step();
    n_checks++;
    if (pc_o !== 32'd8) begin n_fail++; $display("FAIL jal_pc: got %h expected %h", pc_o, 32'd8); end
    read_reg(1, v);
    n_checks++;
    if (v !== 32'd4) begin n_fail++; $display("FAIL jal_link: got %h expected %h", v, 32'd4); end
    step();
    n_checks++;
    if (pc_o !== 32'd4) begin n_fail++; $display("FAIL jalr_pc: got %h expected %h", pc_o, 32'd4); end
    read_reg(0, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL jalr_x0: got %h expected %h", v, 32'd0); end
  endtask

  task automatic test_alu();
    logic [31:0] v;
    hold_reset();
    set_prog(0, 32'h00500113);
    set_prog(1, 32'h002101B3);
    set_prog(2, 32'h402002B3);
    release_reset();
    repeat (3) step();
    read_reg(2, v);
    n_checks++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL alu_x2: got %h expected %h", v, 32'd5); end
    read_reg(3, v);
    n_checks++;
    if (v !== 32'd10) begin n_fail++; $display("FAIL alu_x3: got %h expected %h", v, 32'd10); end
    read_reg(5, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL alu_x5: got %h expected %h", v, 32'hFFFF_FFFB); end
    n_checks++;
    if (pc_o !== 32'd12) begin n_fail++; $display("FAIL alu_pc: got %h expected %h", pc_o, 32'd12); end
  endtask

  task automatic test_memory();
    logic [31:0] v;
    hold_reset();
    set_prog(0, 32'h00500113);
    set_prog(1, 32'h002101B3);
    set_prog(2, 32'h00302023);
    set_prog(3, 32'h00002203);
    release_reset();
    repeat (3) step();
    n_checks++;
    if (dut.mem_data_inst.dataArray[0] !== 32'd10) begin
      n_fail++; $display("FAIL sw_data: got %h expected %h", dut.mem_data_inst.dataArray[0], 32'd10);
    end
    step();
    read_reg(4, v);
    n_checks++;
    if (v !== 32'd10) begin n_fail++; $display("FAIL lw_x4: got %h expected %h", v, 32'd10); end
  endtask

  task automatic test_branches();
    logic [31:0] exp_pc [6] = '{32'd4, 32'd8, 32'd16, 32'd20, 32'd16, 32'd20};
    hold_reset();
    set_prog(0, 32'h00500113);
    set_prog(1, 32'h002101B3);
    set_prog(2, 32'h00314463);
    set_prog(4, 32'h00317463);
    set_prog(5, 32'hFE000EE3);
    release_reset();
    for (int s = 0; s < 6; s++) begin
      step();
      n_checks++;
      if (pc_o !== exp_pc[s]) begin
        n_fail++; $display("FAIL branch_pc step %0d: got %h expected %h", s, pc_o, exp_pc[s]);
      end
    end
  endtask

  task automatic test_illegal_x0();
    logic [31:0] v;
    hold_reset();
    set_prog(0, 32'hFFFF_FFFF);
    set_prog(1, 32'h00700013);
    set_prog(2, 32'h00000073);
    release_reset();
    n_checks++;
    if (illegal_o !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b expected %b", illegal_o, 1'b1); end
    step();
    n_checks++;
    if (pc_o !== 32'd4) begin n_fail++; $display("FAIL illegal_pc: got %h expected %h", pc_o, 32'd4); end
    n_checks++;
    if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL addi_not_illegal: got %b expected %b", illegal_o, 1'b0); end
    for (int r = 0; r < 32; r++) begin
      read_reg(r, v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL illegal_x%0d: got %h expected %h", r, v, 32'h0); end
    end
    step();
    read_reg(0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL x0_write: got %h expected %h", v, 32'h0); end
    n_checks++;
    if (illegal_o !== 1'b1) begin n_fail++; $display("FAIL ecall_illegal: got %b expected %b", illegal_o, 1'b1); end
    step();
    n_checks++;
    if (pc_o !== 32'd12) begin n_fail++; $display("FAIL ecall_pc: got %h expected %h", pc_o, 32'd12); end
  endtask

  // Runs n instructions, comparing fetch, flag, PC and every register each step.
  task automatic run_random_steps(input int n);
    logic [31:0] v;
    for (int s = 0; s < n; s++) begin
      n_checks++;
      if (instr_o !== m_prog[m_pc[9:2]]) begin
        n_fail++; $display("FAIL rand_instr step %0d: got %h expected %h", s, instr_o, m_prog[m_pc[9:2]]);
      end
      n_checks++;
      if (illegal_o !== (find_op(m_prog[m_pc[9:2]]) < 0)) begin
        n_fail++; $display("FAIL rand_illegal step %0d: got %b expected %b", s, illegal_o, find_op(m_prog[m_pc[9:2]]) < 0);
      end
      step();
      m_step();
      n_checks++;
      if (pc_o !== m_pc) begin n_fail++; $display("FAIL rand_pc step %0d: got %h expected %h", s, pc_o, m_pc); end
      for (int r = 0; r < 32; r++) begin
        read_reg(r, v);
        n_checks++;
        if (v !== m_x[r]) begin n_fail++; $display("FAIL rand_x%0d step %0d: got %h expected %h", r, s, v, m_x[r]); end
      end
    end
  endtask

  task automatic test_random();
    hold_reset();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 9) == 0) set_prog(i, $urandom);
      else begin
        int k;
        k = $urandom_range(0, 30);
        set_prog(i, ($urandom & ~t_mask[k]) | t_match[k]);
      end
      set_data(i, $urandom);
    end
    release_reset();
    run_random_steps(300);
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (dut.mem_data_inst.dataArray[i] !== m_data[i]) begin
        n_fail++; $display("FAIL rand_data%0d: got %h expected %h", i, dut.mem_data_inst.dataArray[i], m_data[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    #1 rst_n = 1'b0;
    #0.5;
    n_checks++;
    if (pc_o !== 32'h0) begin n_fail++; $display("FAIL midrst_pc: got %h expected %h", pc_o, 32'h0); end
    for (int r = 0; r < 32; r++) begin
      read_reg(r, v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_x%0d: got %h expected %h", r, v, 32'h0); end
    end
    step();
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (dut.mem_data_inst.dataArray[i] !== m_data[i]) begin
        n_fail++; $display("FAIL midrst_data%0d: got %h expected %h", i, dut.mem_data_inst.dataArray[i], m_data[i]);
      end
    end
    m_pc = 32'h0;
    for (int r = 0; r < 32; r++) m_x[r] = 32'h0;
    release_reset();
    run_random_steps(100);
  endtask

  initial begin
    test_reset();
    test_jal();
    test_alu();
    test_memory();
    test_branches();
    test_illegal_x0();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
